fetch_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch for the MIPS core. Issues word requests to instruction memory over a req/ack handshake and presents each fetched instruction, with its PC, to decode over a valid/ready handshake. Applies branch/jump redirects and exception vectoring, and discards in-flight fetches that a redirect makes stale. Replaces the free-running PC register as the front end of the datapath.

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_sequencer_next_pc_sel.sv | 38 +++
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch front end: the state encoding,
// the data widths, the word size and the default PC vectors.
package fetch_sequencer_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_EXC_VECTOR   = 32'h0000_0080;

    // IDLE: load the request address from the PC
    // FETCH: memory request outstanding
    // VALID: instruction is waiting for decode
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2
    } fetch_state_t;

    // Low address bits that must be zero for a word-aligned target.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC priority mux. Priority order: exception vector, then the exception
// vector for a misaligned redirect, then the redirect target, then seq_base+4.
// Ports:
//   exc_valid, redir_valid, redir_target - redirect request from execute
//   seq_base                             - address the sequential PC follows from
//   target_c                             - selected next address (combinational)
//   redirect_c                           - a redirect event is present this cycle
//   misalign_c                           - redirect target was not word aligned
module fetch_sequencer_next_pc_sel
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic            exc_valid,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic [XLEN-1:0] seq_base,
    output logic [XLEN-1:0] target_c,
    output logic            redirect_c,
    output logic            misalign_c
);

    // A misalignment only counts when no exception takes priority.
    always_comb begin
        target_c   = seq_base + XLEN'(WORD_BYTES);
        redirect_c = exc_valid | redir_valid;
        misalign_c = 1'b0;
        if (exc_valid) begin
            target_c = EXC_VECTOR;
        end else if (redir_valid && is_misaligned(redir_target)) begin
            target_c   = EXC_VECTOR;
            misalign_c = 1'b1;
        end else if (redir_valid) begin
            target_c = redir_target;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer. Owns the PC, issues word requests to
// instruction memory (req/ack) and hands fetched words to decode (valid/ready).
// Redirects and exceptions retarget the PC; a fetch that is outstanding when
// a redirect arrives completes and is then discarded.
// Ports:
//   clk, rst                    - clock, synchronous active-low reset
//   imem_req/addr/ack/rdata     - instruction memory request channel
//   instr_valid/ready/instr/pc  - instruction channel to decode
//   redir_valid/target          - branch taken or jump
//   exc_valid                   - exception, overrides redir_valid
//   misalign_err                - one-cycle pulse for a misaligned redirect
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [XLEN-1:0] EXC_VECTOR   = DEFAULT_EXC_VECTOR
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_target,
    input  logic            exc_valid,
    output logic            misalign_err
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic            flush_pend;

    logic [XLEN-1:0] target_c;
    logic            redirect_c;
    logic            misalign_c;

    // The sequential successor is always taken from the request address, so
    // a clean ack advances to imem_addr+4 and wraps naturally at 2^32.
    fetch_sequencer_next_pc_sel #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_next_pc_sel (
        .exc_valid    (exc_valid),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .seq_base     (imem_addr),
        .target_c     (target_c),
        .redirect_c   (redirect_c),
        .misalign_c   (misalign_c)
    );

    // Handshake outputs are pure decodes of the state register.
    assign imem_req    = (state == ST_FETCH);
    assign instr_valid = (state == ST_VALID);

    // Fetch control, PC and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ST_IDLE;
            pc           <= RESET_VECTOR;
            imem_addr    <= '0;
            flush_pend   <= 1'b0;
            instr        <= '0;
            instr_pc     <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= misalign_c;
            unique case (state)
                ST_IDLE: begin
                    if (redirect_c) begin
                        pc        <= target_c;
                        imem_addr <= target_c;
                    end else begin
                        imem_addr <= pc;
                    end
                    state <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (!imem_ack) begin
                        // The request address is held until ack; remember
                        // that the returning word is stale.
                        if (redirect_c) begin
                            pc         <= target_c;
                            flush_pend <= 1'b1;
                        end
                    end else if (flush_pend || redirect_c) begin
                        // Drop the word and reissue at the current target.
                        flush_pend <= 1'b0;
                        if (redirect_c) begin
                            pc        <= target_c;
                            imem_addr <= target_c;
                        end else begin
                            imem_addr <= pc;
                        end
                    end else begin
                        instr    <= imem_rdata;
                        instr_pc <= imem_addr;
                        pc       <= target_c;
                        state    <= ST_VALID;
                    end
                end

                ST_VALID: begin
                    // A redirect wins over a simultaneous instr_ready.
                    if (redirect_c) begin
                        pc        <= target_c;
                        imem_addr <= target_c;
                        state     <= ST_FETCH;
                    end else if (instr_ready) begin
                        imem_addr <= pc;
                        state     <= ST_FETCH;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Memory returns addr ^ 32'hA5A5_A5A5,
// either acking in the same cycle as the request or under manual control.
module tb_fetch_sequencer;

    localparam logic [31:0] PAT = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_valid;
    logic        misalign_err;

    logic        auto_ack;
    logic        ack_man;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_ack   = auto_ack ? imem_req : ack_man;
    assign imem_rdata = imem_addr ^ PAT;

    fetch_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc_valid    (exc_valid),
        .misalign_err (misalign_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst          = 1'b0;
        auto_ack     = 1'b1;
        ack_man      = 1'b0;
        instr_ready  = 1'b1;
        redir_valid  = 1'b0;
        redir_target = '0;
        exc_valid    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_req",      32'(imem_req), 32'd0);
        chk("rst_valid",    32'(instr_valid), 32'd0);
        chk("rst_misalign", 32'(misalign_err), 32'd0);
        chk("rst_addr",     imem_addr, 32'h0);
        chk("rst_instr",    instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        // Release: first cycle still idle, request in the second
        rst = 1'b1;
        chk("first_cycle_req", 32'(imem_req), 32'd0);
        step();
        chk("second_cycle_req", 32'(imem_req), 32'd1);

        // Zero-wait streaming: one instruction every two cycles
        for (int i = 0; i < 4; i++) begin
            chk("stream_req",  32'(imem_req), 32'd1);
            chk("stream_addr", imem_addr, 32'(i * 4));
            step();
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_pc",    instr_pc, 32'(i * 4));
            chk("stream_instr", instr, 32'(i * 4) ^ PAT);
            step();
        end
        auto_ack = 1'b0;
        chk("stream_next_addr", imem_addr, 32'h10);

        // Redirect during a delayed request: request held, data dropped
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0100;
        step();
        redir_valid = 1'b0;
        chk("wait_addr_hold1", imem_addr, 32'h10);
        chk("wait_req",        32'(imem_req), 32'd1);
        step();
        chk("wait_addr_hold2", imem_addr, 32'h10);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("flush_valid", 32'(instr_valid), 32'd0);
        chk("flush_req",   32'(imem_req), 32'd1);
        chk("flush_addr",  imem_addr, 32'h100);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("redir_valid_out", 32'(instr_valid), 32'd1);
        chk("redir_pc",        instr_pc, 32'h100);
        chk("redir_instr",     instr, 32'hA5A5_A4A5);

        // Backpressure holds the instruction stable
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_pc",    instr_pc, 32'h100);
            chk("stall_instr", instr, 32'hA5A5_A4A5);
        end

        // Redirect beats a simultaneous ready
        instr_ready  = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0040;
        step();
        redir_valid = 1'b0;
        chk("drop_valid", 32'(instr_valid), 32'd0);
        chk("drop_addr",  imem_addr, 32'h40);

        // Misaligned redirect vectors to the exception address
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("pre_mis_pc", instr_pc, 32'h40);
        instr_ready  = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0102;
        step();
        redir_valid = 1'b0;
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_addr",  imem_addr, 32'h80);
        step();
        chk("mis_pulse_end", 32'(misalign_err), 32'd0);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("mis_fetch_pc", instr_pc, 32'h80);

        // Exception overrides a simultaneous redirect
        exc_valid    = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h0000_0200;
        step();
        exc_valid   = 1'b0;
        redir_valid = 1'b0;
        chk("exc_addr",     imem_addr, 32'h80);
        chk("exc_misalign", 32'(misalign_err), 32'd0);
        chk("exc_valid_out", 32'(instr_valid), 32'd0);

        // Redirect to the top word, then sequential wrap to zero
        instr_ready  = 1'b1;
        ack_man      = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'hFFFF_FFFC;
        step();
        redir_valid = 1'b0;
        chk("top_addr",  imem_addr, 32'hFFFF_FFFC);
        chk("top_valid", 32'(instr_valid), 32'd0);
        step();
        ack_man = 1'b0;
        chk("top_pc",    instr_pc, 32'hFFFF_FFFC);
        chk("top_instr", instr, 32'h5A5A_5A59);
        step();
        chk("wrap_addr", imem_addr, 32'h0);

        // Reset in the middle of a pending request
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        step();
        chk("pre_rst_addr", imem_addr, 32'h4);
        step();
        chk("pre_rst_req", 32'(imem_req), 32'd1);
        rst = 1'b0;
        step();
        chk("mid_rst_req",   32'(imem_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_addr",  imem_addr, 32'h0);
        rst = 1'b1;
        step();
        chk("restart_req",  32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
        chk("restart_pc",    instr_pc, 32'h0);
        chk("restart_instr", instr, PAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
